// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit WISC core front end: reset/halt
// defaults, the fetch-stage state encoding and the HLT opcode decode.
package wisc_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;
  localparam logic [15:0] PC_STEP             = 16'h0002;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // True when the instruction word carries the halt opcode in its top nibble.
  function automatic logic is_halt_op(input logic [15:0] instr, input logic [3:0] opcode);
    return (instr[15:12] == opcode);
  endfunction

endpackage

// File: rtl/adder16.sv
// Plain 16-bit modulo adder; carry out is intentionally dropped so that
// address arithmetic wraps (16'hFFFE + 2 = 16'h0000).
module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_fsm.sv
// Fetch-stage control: owns the state register, the registered imem_req and
// halted flags, and decodes per-cycle strobes that steer the datapath.
module fetch_fsm
  import wisc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic br_taken,
  input  logic imem_ready,
  input  logic halt_hit,
  output logic imem_req,
  output logic halted,
  output logic from_hold,
  output logic start_fetch,
  output logic redirect,
  output logic redirect_addr,
  output logic drain_done,
  output logic advance,
  output logic load_ifid,
  output logic capture_hold,
  output logic bubble
);

  fetch_state_e state_r;
  fetch_state_e next_state_s;
  logic         imem_req_r;
  logic         halted_r;

  // The IF/ID source word comes from the hold buffer only while parked in HOLD.
  assign from_hold = (state_r == ST_HOLD);

  // Next-state and datapath strobes; a taken branch always outranks stall and returning data.
  always_comb begin
    next_state_s  = state_r;
    start_fetch   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 1'b0;
    drain_done    = 1'b0;
    advance       = 1'b0;
    load_ifid     = 1'b0;
    capture_hold  = 1'b0;
    bubble        = 1'b0;
    case (state_r)
      ST_START: begin
        next_state_s = ST_FETCH;
        if (br_taken) begin
          redirect      = 1'b1;
          redirect_addr = 1'b1;
        end else begin
          start_fetch   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (br_taken) begin
          redirect = 1'b1;
          if (imem_ready) begin
            // Data returned this cycle is simply dropped; restart at the target.
            redirect_addr = 1'b1;
            next_state_s  = ST_FETCH;
          end else begin
            // Request still in flight: keep the old address on the bus until it completes.
            next_state_s  = ST_DRAIN;
          end
        end else if (imem_ready && !stall) begin
          load_ifid = 1'b1;
          if (halt_hit) begin
            next_state_s = ST_HALT;
          end else begin
            advance      = 1'b1;
            next_state_s = ST_FETCH;
          end
        end else if (imem_ready) begin
          capture_hold = 1'b1;
          next_state_s = ST_HOLD;
        end else if (!stall) begin
          bubble       = 1'b1;
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (br_taken) begin
          redirect      = 1'b1;
          redirect_addr = 1'b1;
          next_state_s  = ST_FETCH;
        end else if (!stall) begin
          load_ifid = 1'b1;
          if (halt_hit) begin
            next_state_s = ST_HALT;
          end else begin
            advance      = 1'b1;
            next_state_s = ST_FETCH;
          end
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (br_taken) begin
          redirect = 1'b1;
        end else begin
          redirect = 1'b0;
        end
        if (imem_ready) begin
          next_state_s = ST_FETCH;
          if (br_taken) begin
            redirect_addr = 1'b1;
          end else begin
            drain_done    = 1'b1;
          end
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_HALT: begin
        if (br_taken) begin
          redirect      = 1'b1;
          redirect_addr = 1'b1;
          next_state_s  = ST_FETCH;
        end else begin
          next_state_s  = ST_HALT;
        end
      end
      default: begin
        next_state_s = ST_START;
      end
    endcase
  end

  // State register with imem_req/halted registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_START;
      imem_req_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      imem_req_r <= (next_state_s == ST_FETCH) || (next_state_s == ST_DRAIN);
      halted_r   <= (next_state_s == ST_HALT);
    end
  end

  assign imem_req = imem_req_r;
  assign halted   = halted_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: architectural PC, fetch address, stall hold
// buffer and the IF/ID pipeline register. Control lives in fetch_fsm.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic [15:0] if_instr,
  output logic        halted
);

  logic [15:0] pc_r;
  logic [15:0] fetch_addr_r;
  logic [15:0] hold_buf_r;
  logic        if_valid_r;
  logic [15:0] if_pc_r;
  logic [15:0] if_pc_plus2_r;
  logic [15:0] if_instr_r;

  logic [15:0] addr_plus2_s;
  logic [15:0] load_word_s;
  logic        halt_hit_s;
  logic        from_hold_s;
  logic        start_fetch_s;
  logic        redirect_s;
  logic        redirect_addr_s;
  logic        drain_done_s;
  logic        advance_s;
  logic        load_ifid_s;
  logic        capture_hold_s;
  logic        bubble_s;

  adder16 u_inc (
    .a   (fetch_addr_r),
    .b   (PC_STEP),
    .sum (addr_plus2_s)
  );

  assign load_word_s = from_hold_s ? hold_buf_r : imem_rdata;
  assign halt_hit_s  = is_halt_op(load_word_s, HALT_OPCODE);

  fetch_fsm u_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .br_taken      (br_taken),
    .imem_ready    (imem_ready),
    .halt_hit      (halt_hit_s),
    .imem_req      (imem_req),
    .halted        (halted),
    .from_hold     (from_hold_s),
    .start_fetch   (start_fetch_s),
    .redirect      (redirect_s),
    .redirect_addr (redirect_addr_s),
    .drain_done    (drain_done_s),
    .advance       (advance_s),
    .load_ifid     (load_ifid_s),
    .capture_hold  (capture_hold_s),
    .bubble        (bubble_s)
  );

  // PC and fetch address; during DRAIN only pc follows the branch so the bus address stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= RESET_PC;
      fetch_addr_r <= RESET_PC;
    end else begin
      if (redirect_s) begin
        pc_r <= br_target;
      end else if (advance_s) begin
        pc_r <= addr_plus2_s;
      end
      if (redirect_addr_s) begin
        fetch_addr_r <= br_target;
      end else if (drain_done_s || start_fetch_s) begin
        fetch_addr_r <= pc_r;
      end else if (advance_s) begin
        fetch_addr_r <= addr_plus2_s;
      end
    end
  end

  // Parks a word that returned while decode was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_buf_r <= 16'h0000;
    end else if (capture_hold_s) begin
      hold_buf_r <= imem_rdata;
    end
  end

  // IF/ID register: flush on redirect, load on accepted word, bubble on an unstalled wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_r    <= 1'b0;
      if_pc_r       <= 16'h0000;
      if_pc_plus2_r <= 16'h0000;
      if_instr_r    <= 16'h0000;
    end else if (redirect_s) begin
      if_valid_r    <= 1'b0;
    end else if (load_ifid_s) begin
      if_valid_r    <= 1'b1;
      if_pc_r       <= fetch_addr_r;
      if_pc_plus2_r <= addr_plus2_s;
      if_instr_r    <= load_word_s;
    end else if (bubble_s) begin
      if_valid_r    <= 1'b0;
    end
  end

  assign imem_addr   = fetch_addr_r;
  assign if_valid    = if_valid_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus2 = if_pc_plus2_r;
  assign if_instr    = if_instr_r;

endmodule
